minmax_seq: RTL and testbench

- Sequencer that streams a burst of LEN 32-bit samples through one shared three-way magnitude comparator. Tracks the running maximum and minimum and their sample indices.
- The comparator is time-shared: one compare against the current max, then one against the current min, per sample.
- Sits between a sample source with a valid/ready handshake and a control/status consumer that issues start and waits for the done pulse.

---
 rtl/minmax_seq_pkg.sv | 15 +
 rtl/minmax_seq_if.sv | 31 +++
 rtl/minmax_seq_mag_cmp_3way.sv | 25 ++
 rtl/minmax_seq.sv | 159 +++++++++++++++
 tb/tb_minmax_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/minmax_seq_pkg.sv
// Shared types and default widths for the minmax_seq burst min/max tracker.
package minmax_seq_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/minmax_seq_if.sv
// Sample stream plus control/status bundle for minmax_seq.
interface minmax_seq_if
    import minmax_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) ();

    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] max_out;
    logic [DATA_W-1:0] min_out;
    logic [CNT_W-1:0]  max_idx;
    logic [CNT_W-1:0]  min_idx;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, busy, done, max_out, min_out, max_idx, min_idx
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, busy, done, max_out, min_out, max_idx, min_idx
    );

endinterface

// File: rtl/minmax_seq_mag_cmp_3way.sv
// Combinational three-way magnitude comparator; exactly one output is high.
// Build with MINMAX_SIGNED_CMP_EN defined for a two's-complement compare.
module mag_cmp_3way
    import minmax_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] p_i,
    input  logic [DATA_W-1:0] q_i,
    output logic              pbig_o,
    output logic              same_o,
    output logic              qbig_o
);

    always_comb begin
        same_o = (p_i == q_i);
`ifdef MINMAX_SIGNED_CMP_EN
        pbig_o = ($signed(p_i) > $signed(q_i));
`else
        pbig_o = (p_i > q_i);
`endif
        qbig_o = ~pbig_o & ~same_o;
    end

endmodule

// File: rtl/minmax_seq.sv
// Burst sequencer tracking running max/min (and indices) through one shared comparator.
// MINMAX_SIGNED_CMP_EN selects a signed compare inside mag_cmp_3way.
module minmax_seq
    import minmax_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input logic         clk,
    input logic         rst,
    minmax_seq_if.slave bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [CNT_W-1:0]  max_idx_q, max_idx_d;
    logic [CNT_W-1:0]  min_idx_q, min_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer_c;
    logic [DATA_W-1:0] cmp_q_c;
    logic              cmp_pbig_c, cmp_same_c, cmp_qbig_c;
    logic              cmp_unused_c;

    assign xfer_c       = bus.in_valid & in_ready_q;
    assign cmp_unused_c = cmp_same_c;

    // Single comparator: P is always the captured sample, Q follows the phase.
    assign cmp_q_c = (state_q == CMP_MIN) ? min_q : max_q;

    mag_cmp_3way #(.DATA_W(DATA_W)) u_cmp (
        .p_i    (sample_q),
        .q_i    (cmp_q_c),
        .pbig_o (cmp_pbig_c),
        .same_o (cmp_same_c),
        .qbig_o (cmp_qbig_c)
    );

    // Next-state and result update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        sample_d  = sample_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        len_d   = bus.len;
                        idx_d   = '0;
                        state_d = ACCEPT;
                    end else begin
                        max_d     = '0;
                        min_d     = '0;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        state_d   = DONE;
                    end
                end
            end
            ACCEPT: begin
                if (xfer_c) begin
                    if (idx_q == '0) begin
                        max_d     = bus.in_data;
                        min_d     = bus.in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        if (len_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = CNT_W'(1);
                        end
                    end else begin
                        sample_d = bus.in_data;
                        state_d  = CMP_MAX;
                    end
                end
            end
            CMP_MAX: begin
                // Ties never update, so the earliest index is kept.
                if (cmp_pbig_c) begin
                    max_d     = sample_q;
                    max_idx_d = idx_q;
                end
                state_d = CMP_MIN;
            end
            CMP_MIN: begin
                if (cmp_qbig_c) begin
                    min_d     = sample_q;
                    min_idx_d = idx_q;
                end
                if (idx_q == (len_q - CNT_W'(1))) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = ACCEPT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == ACCEPT);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            sample_q   <= '0;
            max_q      <= '0;
            min_q      <= '0;
            max_idx_q  <= '0;
            min_idx_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            sample_q   <= sample_d;
            max_q      <= max_d;
            min_q      <= min_d;
            max_idx_q  <= max_idx_d;
            min_idx_q  <= min_idx_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.max_out  = max_q;
    assign bus.min_out  = min_q;
    assign bus.max_idx  = max_idx_q;
    assign bus.min_idx  = min_idx_q;

endmodule

// File: tb/tb_minmax_seq.sv
// Directed self-checking bench for minmax_seq (unsigned or MINMAX_SIGNED_CMP_EN build).
module tb_minmax_seq;
    import minmax_seq_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] smp [8];
    logic [15:0] gap_mask;
    int          extra_start_cyc;

    minmax_seq_if bus ();

    minmax_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one burst; cyc counts edges after the edge that sampled start.
    task automatic run_burst(input logic [7:0] l, input int n, output int done_at,
                             output int pulses, output bit rdy_seen, output int cmp_seen);
        int k;
        bit acc;
        k = 0; done_at = -1; pulses = 0; rdy_seen = 1'b0; cmp_seen = 0;
        bus.start = 1'b1; bus.len = l; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (bus.done) begin
                pulses++;
                if (done_at < 0) done_at = cyc;
            end
            if (bus.in_ready) rdy_seen = 1'b1;
            if (dut.state_q == CMP_MAX || dut.state_q == CMP_MIN) cmp_seen++;
            if (done_at >= 0 && cyc > done_at) break;
            bus.start    = (cyc == extra_start_cyc);
            bus.len      = (cyc == extra_start_cyc) ? 8'd5 : l;
            bus.in_valid = bus.in_ready && (k < n) && !gap_mask[cyc % 16];
            bus.in_data  = (k < n) ? smp[k] : 32'd0;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) k++;
        end
        bus.start = 1'b0; bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", bus.done); end
        tests++; if (bus.max_out !== 32'd0 || bus.min_out !== 32'd0) begin fails++; $display("FAIL rst_results: got max %h min %h want 0", bus.max_out, bus.min_out); end
        tests++; if (bus.max_idx !== 8'd0 || bus.min_idx !== 8'd0) begin fails++; $display("FAIL rst_idx: got %0d/%0d want 0/0", bus.max_idx, bus.min_idx); end
    endtask

    task automatic test_len4();
        int da, pu, cs; bit rs;
        smp[0] = 32'd5; smp[1] = 32'd9; smp[2] = 32'd2; smp[3] = 32'd9;
        run_burst(8'd4, 4, da, pu, rs, cs);
        tests++; if (bus.max_out !== 32'd9) begin fails++; $display("FAIL len4_max: got %0d want 9", bus.max_out); end
        tests++; if (bus.max_idx !== 8'd1) begin fails++; $display("FAIL len4_max_idx: got %0d want 1", bus.max_idx); end
        tests++; if (bus.min_out !== 32'd2) begin fails++; $display("FAIL len4_min: got %0d want 2", bus.min_out); end
        tests++; if (bus.min_idx !== 8'd2) begin fails++; $display("FAIL len4_min_idx: got %0d want 2", bus.min_idx); end
        // First sample takes 1 edge, each later sample 3 edges: done rises on edge 3N-2.
        tests++; if (da !== 10) begin fails++; $display("FAIL len4_done_at: got %0d want 10", da); end
        tests++; if (pu !== 1) begin fails++; $display("FAIL len4_pulses: got %0d want 1", pu); end
    endtask

    task automatic test_len1();
        int da, pu, cs; bit rs;
        smp[0] = 32'h1234;
        run_burst(8'd1, 1, da, pu, rs, cs);
        tests++; if (bus.max_out !== 32'h1234 || bus.min_out !== 32'h1234) begin fails++; $display("FAIL len1_vals: got max %h min %h want 1234", bus.max_out, bus.min_out); end
        tests++; if (bus.max_idx !== 8'd0 || bus.min_idx !== 8'd0) begin fails++; $display("FAIL len1_idx: got %0d/%0d want 0/0", bus.max_idx, bus.min_idx); end
        tests++; if (da !== 1) begin fails++; $display("FAIL len1_done_at: got %0d want 1", da); end
        tests++; if (cs !== 0) begin fails++; $display("FAIL len1_cmp_states: got %0d want 0", cs); end
    endtask

    task automatic test_len0();
        int da, pu, cs; bit rs;
        run_burst(8'd0, 0, da, pu, rs, cs);
        tests++; if (da !== 0) begin fails++; $display("FAIL len0_done_at: got %0d want 0", da); end
        tests++; if (pu !== 1) begin fails++; $display("FAIL len0_pulses: got %0d want 1", pu); end
        tests++; if (rs !== 1'b0) begin fails++; $display("FAIL len0_ready_seen: got %b want 0", rs); end
        tests++; if (bus.max_out !== 32'd0 || bus.min_out !== 32'd0) begin fails++; $display("FAIL len0_results: got max %h min %h want 0", bus.max_out, bus.min_out); end
        tests++; if (bus.max_idx !== 8'd0 || bus.min_idx !== 8'd0) begin fails++; $display("FAIL len0_idx: got %0d/%0d want 0/0", bus.max_idx, bus.min_idx); end
    endtask

    task automatic test_gaps();
        int da, pu, cs, busy_cnt; bit rs;
        logic [31:0] emax, emin;
        logic [7:0]  emax_i, emin_i;
`ifdef MINMAX_SIGNED_CMP_EN
        emax = 32'd7;          emax_i = 8'd2;
        emin = 32'hFFFF_FFFF;  emin_i = 8'd1;
`else
        emax = 32'hFFFF_FFFF;  emax_i = 8'd1;
        emin = 32'd1;          emin_i = 8'd0;
`endif
        smp[0] = 32'd1; smp[1] = 32'hFFFF_FFFF; smp[2] = 32'd7;
        gap_mask = 16'b0110_0101_1001_0110;
        extra_start_cyc = 4;
        run_burst(8'd3, 3, da, pu, rs, cs);
        gap_mask = 16'h0000;
        extra_start_cyc = -1;
        tests++; if (da < 0) begin fails++; $display("FAIL gaps_timeout: got no done want done"); end
        tests++; if (pu !== 1) begin fails++; $display("FAIL gaps_pulses: got %0d want 1", pu); end
        tests++; if (bus.max_out !== emax || bus.max_idx !== emax_i) begin fails++; $display("FAIL gaps_max: got %h@%0d want %h@%0d", bus.max_out, bus.max_idx, emax, emax_i); end
        tests++; if (bus.min_out !== emin || bus.min_idx !== emin_i) begin fails++; $display("FAIL gaps_min: got %h@%0d want %h@%0d", bus.min_out, bus.min_idx, emin, emin_i); end
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_cnt++;
        end
        tests++; if (busy_cnt !== 0) begin fails++; $display("FAIL gaps_extra_start: got %0d busy cycles want 0", busy_cnt); end
    endtask

    task automatic test_reset_mid();
        int da, pu, cs; bit rs;
        bus.start = 1'b1; bus.len = 8'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'd5;
        @(posedge clk); #1;
        bus.in_data = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        tests++; if (dut.state_q !== CMP_MAX || bus.busy !== 1'b1 || bus.max_out !== 32'd5) begin fails++; $display("FAIL mid_pre: got state %0d busy %b max %0d want 2 1 5", dut.state_q, bus.busy, bus.max_out); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.max_out !== 32'd0 || bus.min_out !== 32'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL mid_async: got max %h min %h busy %b rdy %b done %b want all 0", bus.max_out, bus.min_out, bus.busy, bus.in_ready, bus.done); end
        tests++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL mid_state: got %0d want 0", dut.state_q); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        smp[0] = 32'd8; smp[1] = 32'd20;
        run_burst(8'd2, 2, da, pu, rs, cs);
        tests++; if (bus.max_out !== 32'd20 || bus.max_idx !== 8'd1) begin fails++; $display("FAIL mid_after_max: got %0d@%0d want 20@1", bus.max_out, bus.max_idx); end
        tests++; if (bus.min_out !== 32'd8 || bus.min_idx !== 8'd0) begin fails++; $display("FAIL mid_after_min: got %0d@%0d want 8@0", bus.min_out, bus.min_idx); end
        tests++; if (da !== 4) begin fails++; $display("FAIL mid_after_done_at: got %0d want 4", da); end
    endtask

    task automatic test_back_to_back();
        int da, pu, cs; bit rs;
        smp[0] = 32'd100; smp[1] = 32'd4;
        run_burst(8'd2, 2, da, pu, rs, cs);
        tests++; if (bus.max_out !== 32'd100 || bus.min_out !== 32'd4 || bus.max_idx !== 8'd0 || bus.min_idx !== 8'd1) begin fails++; $display("FAIL b2b_first: got %0d@%0d %0d@%0d want 100@0 4@1", bus.max_out, bus.max_idx, bus.min_out, bus.min_idx); end
        smp[0] = 32'd3; smp[1] = 32'd3; smp[2] = 32'd3;
        run_burst(8'd3, 3, da, pu, rs, cs);
        tests++; if (bus.max_out !== 32'd3 || bus.max_idx !== 8'd0) begin fails++; $display("FAIL b2b_max: got %0d@%0d want 3@0", bus.max_out, bus.max_idx); end
        tests++; if (bus.min_out !== 32'd3 || bus.min_idx !== 8'd0) begin fails++; $display("FAIL b2b_min: got %0d@%0d want 3@0", bus.min_out, bus.min_idx); end
        tests++; if (da !== 7) begin fails++; $display("FAIL b2b_done_at: got %0d want 7", da); end
    endtask

    initial begin
        tests = 0; fails = 0;
        bus.start = 1'b0; bus.len = 8'd0; bus.in_valid = 1'b0; bus.in_data = 32'd0;
        gap_mask = 16'h0000; extra_start_cyc = -1;
        for (int i = 0; i < 8; i++) smp[i] = 32'd0;
        test_reset();
        test_len4();
        test_len1();
        test_len0();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
